// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared types for the regfile write-port arbiter: register address/data
// widths and the packed writeback request record.
package regfile_wport_arbiter_pkg;

  localparam int RF_NREGS = 32;

  typedef logic [4:0]  rf_addr_t;
  typedef logic [31:0] rf_data_t;

  typedef struct packed {
    rf_addr_t dest;
    rf_data_t data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wport_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after ptr, wrapping around. Reusable for any N-way port share.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] winner,
  output logic          any
);

  int unsigned idx;

  always_comb begin
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        winner     = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Shares the regfile write port between NREQ writeback sources with a
// registered commit stage and a per-register pending-write scoreboard.
// Optional macro RF_BYPASS_EN adds commit-cycle forwarding to decode.
//
// Handshake: requester i holds req_valid[i] with its dest/data; the write is
// taken in the cycle req_ready[i]=1 (at most one bit set, combinational).
// alloc is taken in a cycle where alloc_valid && alloc_ready.
module regfile_wport_arbiter
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*5-1:0]  req_dest,
  input  logic [NREQ*32-1:0] req_data,
  input  logic              alloc_valid,
  input  logic [4:0]        alloc_dest,
  output logic              alloc_ready,
  input  logic [4:0]        src_a,
  input  logic [4:0]        src_b,
  output logic              hazard_a,
  output logic              hazard_b,
`ifdef RF_BYPASS_EN
  output logic              fwd_a,
  output logic              fwd_b,
  output logic [31:0]       fwd_data_a,
  output logic [31:0]       fwd_data_b,
`endif
  output logic              rf_load,
  output logic [4:0]        rf_dest,
  output logic [31:0]       rf_in
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  wb_req_t         reqs [NREQ];
  wb_req_t         sel;
  logic [PW-1:0]   rr;
  logic [PW-1:0]   win_idx;
  logic            win_any;
  logic [PEND_W-1:0] cnt [RF_NREGS];
  logic            alloc_fire;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      reqs[i].dest = req_dest[i*5 +: 5];
      reqs[i].data = req_data[i*32 +: 32];
    end
  end

  rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
    .req    (req_valid),
    .ptr    (rr),
    .grant  (req_ready),
    .winner (win_idx),
    .any    (win_any)
  );

  assign sel = reqs[win_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      rr <= '0;
    end else if (win_any) begin
      rr <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
    end
  end

  // x0 writes are accepted but never reach the regfile; dest/data then hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_load <= 1'b0;
      rf_dest <= '0;
      rf_in   <= '0;
    end else begin
      rf_load <= win_any && (sel.dest != '0);
      if (win_any && (sel.dest != '0)) begin
        rf_dest <= sel.dest;
        rf_in   <= sel.data;
      end
    end
  end

  assign alloc_ready = (alloc_dest == '0) || (cnt[alloc_dest] != '1);
  assign alloc_fire  = alloc_valid && alloc_ready && (alloc_dest != '0);

  // Decrement saturates at zero so an unreserved commit cannot underflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < RF_NREGS; r++) cnt[r] <= '0;
    end else begin
      cnt[0] <= '0;
      for (int r = 1; r < RF_NREGS; r++) begin
        if (alloc_fire && (alloc_dest == 5'(r))) begin
          if (!(rf_load && (rf_dest == 5'(r)))) cnt[r] <= cnt[r] + PEND_W'(1);
        end else if (rf_load && (rf_dest == 5'(r)) && (cnt[r] != '0)) begin
          cnt[r] <= cnt[r] - PEND_W'(1);
        end
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && rf_load && (rf_dest != '0)) begin
      assert (cnt[rf_dest] != '0)
        else $error("commit to x%0d with no outstanding reservation", rf_dest);
    end
  end
`endif

`ifdef RF_BYPASS_EN
  logic byp_a, byp_b;
  assign byp_a      = rf_load && (rf_dest == src_a) && (cnt[src_a] == PEND_W'(1));
  assign byp_b      = rf_load && (rf_dest == src_b) && (cnt[src_b] == PEND_W'(1));
  assign fwd_a      = byp_a;
  assign fwd_b      = byp_b;
  assign fwd_data_a = rf_in;
  assign fwd_data_b = rf_in;
  assign hazard_a   = (cnt[src_a] != '0) && !byp_a;
  assign hazard_b   = (cnt[src_b] != '0) && !byp_b;
`else
  assign hazard_a   = (cnt[src_a] != '0);
  assign hazard_b   = (cnt[src_b] != '0);
`endif

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed bench for regfile_wport_arbiter (default build and RF_BYPASS_EN).
module tb_regfile_wport_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [9:0]  req_dest;
  logic [63:0] req_data;
  logic        alloc_valid;
  logic [4:0]  alloc_dest;
  logic        alloc_ready;
  logic [4:0]  src_a, src_b;
  logic        hazard_a, hazard_b;
`ifdef RF_BYPASS_EN
  logic        fwd_a, fwd_b;
  logic [31:0] fwd_data_a, fwd_data_b;
`endif
  logic        rf_load;
  logic [4:0]  rf_dest;
  logic [31:0] rf_in;

  int checks = 0;
  int failures = 0;

  regfile_wport_arbiter #(.NREQ(2), .PEND_W(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dest(req_dest), .req_data(req_data),
    .alloc_valid(alloc_valid), .alloc_dest(alloc_dest), .alloc_ready(alloc_ready),
    .src_a(src_a), .src_b(src_b), .hazard_a(hazard_a), .hazard_b(hazard_b),
`ifdef RF_BYPASS_EN
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b),
`endif
    .rf_load(rf_load), .rf_dest(rf_dest), .rf_in(rf_in)
  );

  // clock/reset block
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [4:0] d);
    alloc_valid = 1'b1;
    alloc_dest  = d;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] d, input logic [31:0] x);
    req_valid[i]        = v;
    req_dest[i*5 +: 5]  = d;
    req_data[i*32 +: 32] = x;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_dest = '0; req_data = '0;
    alloc_valid = 1'b0; alloc_dest = '0; src_a = 5'd5; src_b = 5'd7;
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (rf_load !== 1'b0) begin failures++; $display("FAIL reset_rf_load got=%b exp=0", rf_load); end
    checks++; if (rf_dest !== 5'd0) begin failures++; $display("FAIL reset_rf_dest got=%0d exp=0", rf_dest); end
    checks++; if (rf_in !== 32'd0) begin failures++; $display("FAIL reset_rf_in got=%h exp=0", rf_in); end
    checks++; if ({hazard_a, hazard_b} !== 2'b00) begin failures++; $display("FAIL reset_hazards got=%b exp=00", {hazard_a, hazard_b}); end
  endtask

  task automatic test_reset_mid_commit();
    src_a = 5'd5;
    alloc(5'd5);
    checks++; if (hazard_a !== 1'b1) begin failures++; $display("FAIL rmc_hazard_pre got=%b exp=1", hazard_a); end
    set_req(0, 1'b1, 5'd5, 32'h0000_DEAD);
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rmc_ready got=%b exp=01", req_ready); end
    tick();
    req_valid = '0;
    checks++; if ({rf_load, rf_dest, rf_in} !== {1'b1, 5'd5, 32'h0000_DEAD}) begin
      failures++; $display("FAIL rmc_commit got=%b/%0d/%h exp=1/5/0000dead", rf_load, rf_dest, rf_in); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if ({rf_load, rf_dest, rf_in} !== {1'b0, 5'd0, 32'd0}) begin
      failures++; $display("FAIL rmc_rf_after_rst got=%b/%0d/%h exp=0/0/0", rf_load, rf_dest, rf_in); end
    checks++; if (hazard_a !== 1'b0) begin failures++; $display("FAIL rmc_hazard_after_rst got=%b exp=0", hazard_a); end
    // rr was 1 before reset; both valid must now grant requester 0
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rmc_rr_reset got=%b exp=01", req_ready); end
    req_valid = '0;
    #1;
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL idle_ready got=%b exp=00", req_ready); end
  endtask

  task automatic test_contention();
    logic [1:0]  exp_grant [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [4:0]  exp_dest  [4] = '{5'd1, 5'd2, 5'd1, 5'd2};
    logic [31:0] exp_data  [4] = '{32'hA000_0000, 32'hB000_0001, 32'hA000_0002, 32'hB000_0003};
    alloc(5'd1); alloc(5'd1); alloc(5'd2); alloc(5'd2);
    for (int k = 0; k < 4; k++) begin
      set_req(0, 1'b1, 5'd1, 32'hA000_0000 | k);
      set_req(1, 1'b1, 5'd2, 32'hB000_0000 | k);
      #1;
      checks++; if (req_ready !== exp_grant[k]) begin failures++; $display("FAIL cont_grant%0d got=%b exp=%b", k, req_ready, exp_grant[k]); end
      tick();
      checks++; if ({rf_load, rf_dest, rf_in} !== {1'b1, exp_dest[k], exp_data[k]}) begin
        failures++; $display("FAIL cont_commit%0d got=%b/%0d/%h exp=1/%0d/%h", k, rf_load, rf_dest, rf_in, exp_dest[k], exp_data[k]); end
    end
    req_valid = '0;
    src_a = 5'd1; src_b = 5'd2;
    tick();
    checks++; if ({rf_load, rf_dest, rf_in} !== {1'b0, 5'd2, 32'hB000_0003}) begin
      failures++; $display("FAIL cont_hold got=%b/%0d/%h exp=0/2/b0000003", rf_load, rf_dest, rf_in); end
    checks++; if ({hazard_a, hazard_b} !== 2'b00) begin failures++; $display("FAIL cont_drained got=%b exp=00", {hazard_a, hazard_b}); end
  endtask

  task automatic test_x0_write();
    set_req(0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL x0_ready got=%b exp=01", req_ready); end
    tick();
    req_valid = '0;
    checks++; if ({rf_load, rf_dest, rf_in} !== {1'b0, 5'd2, 32'hB000_0003}) begin
      failures++; $display("FAIL x0_no_load got=%b/%0d/%h exp=0/2/b0000003", rf_load, rf_dest, rf_in); end
    alloc_dest = 5'd0; src_a = 5'd0;
    #1;
    checks++; if (alloc_ready !== 1'b1) begin failures++; $display("FAIL x0_alloc_ready got=%b exp=1", alloc_ready); end
    alloc(5'd0);
    checks++; if (hazard_a !== 1'b0) begin failures++; $display("FAIL x0_alloc_hazard got=%b exp=0", hazard_a); end
  endtask

  task automatic test_scoreboard();
    // rr is 1 here (last accept was requester 0)
    src_a = 5'd7;
    alloc(5'd7); alloc(5'd7);
    checks++; if (hazard_a !== 1'b1) begin failures++; $display("FAIL sb_hazard_cnt2 got=%b exp=1", hazard_a); end
    alloc_dest = 5'd7;
    #1;
    checks++; if (alloc_ready !== 1'b1) begin failures++; $display("FAIL sb_ready_cnt2 got=%b exp=1", alloc_ready); end
    alloc(5'd7);
    checks++; if (alloc_ready !== 1'b0) begin failures++; $display("FAIL sb_ready_full got=%b exp=0", alloc_ready); end
    alloc(5'd7);
    checks++; if (alloc_ready !== 1'b0) begin failures++; $display("FAIL sb_full_blocked got=%b exp=0", alloc_ready); end
    for (int k = 0; k < 3; k++) begin
      set_req(1, 1'b1, 5'd7, 32'h7777_0000 | k);
      #1;
      checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL sb_grant%0d got=%b exp=10", k, req_ready); end
      tick();
    end
    req_valid = '0;
    // three accepts done: third commit visible now, cnt[7]=1
    checks++; if ({rf_load, rf_dest, rf_in} !== {1'b1, 5'd7, 32'h7777_0002}) begin
      failures++; $display("FAIL sb_commit3 got=%b/%0d/%h exp=1/7/77770002", rf_load, rf_dest, rf_in); end
`ifdef RF_BYPASS_EN
    checks++; if (hazard_a !== 1'b0) begin failures++; $display("FAIL sb_hazard_last got=%b exp=0", hazard_a); end
`else
    checks++; if (hazard_a !== 1'b1) begin failures++; $display("FAIL sb_hazard_last got=%b exp=1", hazard_a); end
`endif
    tick();
    checks++; if (hazard_a !== 1'b0) begin failures++; $display("FAIL sb_hazard_drop got=%b exp=0", hazard_a); end
  endtask

  task automatic test_same_cycle();
    src_a = 5'd9;
    alloc(5'd9);
    set_req(0, 1'b1, 5'd9, 32'h0000_0909);
    tick();
    req_valid = '0;
    alloc_valid = 1'b1; alloc_dest = 5'd9;
    #1;
    checks++; if ({rf_load, rf_dest, alloc_ready} !== {1'b1, 5'd9, 1'b1}) begin
      failures++; $display("FAIL sc_setup got=%b/%0d/%b exp=1/9/1", rf_load, rf_dest, alloc_ready); end
    tick();
    alloc_valid = 1'b0;
    checks++; if ({rf_load, hazard_a} !== 2'b01) begin failures++; $display("FAIL sc_cnt_kept got=%b exp=01", {rf_load, hazard_a}); end
    set_req(0, 1'b1, 5'd9, 32'h0000_0A0A);
    tick();
    req_valid = '0;
    tick();
    checks++; if (hazard_a !== 1'b0) begin failures++; $display("FAIL sc_drained got=%b exp=0", hazard_a); end
  endtask

`ifdef RF_BYPASS_EN
  task automatic test_bypass();
    src_a = 5'd3; src_b = 5'd3;
    alloc(5'd3);
    set_req(0, 1'b1, 5'd3, 32'h0000_1234);
    tick();
    req_valid = '0;
    checks++; if ({hazard_a, fwd_a, fwd_data_a} !== {1'b0, 1'b1, 32'h0000_1234}) begin
      failures++; $display("FAIL byp_a got=%b/%b/%h exp=0/1/00001234", hazard_a, fwd_a, fwd_data_a); end
    checks++; if ({hazard_b, fwd_b, fwd_data_b} !== {1'b0, 1'b1, 32'h0000_1234}) begin
      failures++; $display("FAIL byp_b got=%b/%b/%h exp=0/1/00001234", hazard_b, fwd_b, fwd_data_b); end
    tick();
    checks++; if ({hazard_a, fwd_a} !== 2'b00) begin failures++; $display("FAIL byp_after got=%b exp=00", {hazard_a, fwd_a}); end
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid_commit();
    test_contention();
    test_x0_write();
    test_scoreboard();
    test_same_cycle();
`ifdef RF_BYPASS_EN
    test_bypass();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
